// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the process scheduler.
//   - scheduler FSM state encoding
//   - default slot count and saved-PC width
//   - pid of the OS kernel slot
package process_scheduler_pkg;

    localparam int unsigned NPROC_DEFAULT = 8;
    localparam int unsigned PCW_DEFAULT   = 32;
    localparam int unsigned OS_PID        = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSave   = 2'd1,
        StSearch = 2'd2,
        StLoad   = 2'd3
    } state_e;

endpackage

// File: rtl/process_scheduler_if.sv
// Bus between the CPU/timer side (master) and the process scheduler (slave).
//   master drives: cs_req, pc_in, create, create_pid, create_pc, kill, kill_pid
//   slave drives : cur_pid, next_pc, switch_done, busy, idle_os
//   with PROCESS_SCHEDULER_STATS_EN defined the slave also drives
//   switch_count and last_search_len.
interface process_scheduler_if
    import process_scheduler_pkg::*;
#(
    parameter int unsigned NPROC = NPROC_DEFAULT,
    parameter int unsigned PCW   = PCW_DEFAULT
) ();
    localparam int unsigned PIDW = $clog2(NPROC);

    logic            cs_req;
    logic [PCW-1:0]  pc_in;
    logic            create;
    logic [PIDW-1:0] create_pid;
    logic [PCW-1:0]  create_pc;
    logic            kill;
    logic [PIDW-1:0] kill_pid;
    logic [PIDW-1:0] cur_pid;
    logic [PCW-1:0]  next_pc;
    logic            switch_done;
    logic            busy;
    logic            idle_os;
`ifdef PROCESS_SCHEDULER_STATS_EN
    logic [15:0]     switch_count;
    logic [PIDW-1:0] last_search_len;
`endif

    modport master (
`ifdef PROCESS_SCHEDULER_STATS_EN
        input  switch_count,
        input  last_search_len,
`endif
        output cs_req,
        output pc_in,
        output create,
        output create_pid,
        output create_pc,
        output kill,
        output kill_pid,
        input  cur_pid,
        input  next_pc,
        input  switch_done,
        input  busy,
        input  idle_os
    );

    modport slave (
`ifdef PROCESS_SCHEDULER_STATS_EN
        output switch_count,
        output last_search_len,
`endif
        input  cs_req,
        input  pc_in,
        input  create,
        input  create_pid,
        input  create_pc,
        input  kill,
        input  kill_pid,
        output cur_pid,
        output next_pc,
        output switch_done,
        output busy,
        output idle_os
    );

endinterface

// File: rtl/process_scheduler_pid_table.sv
// Per-slot valid bits and saved-PC storage for the process scheduler.
//   clock, reset              : clock, synchronous active-high reset
//   save_en/pid/pc            : PC write from the SAVE state
//   create_en/pid/pc          : PC write + set valid (same write port, create wins)
//   kill_en/pid               : clear valid (wins over create on the same pid)
//   rd_pid -> rd_pc           : combinational read port
//   valid                     : all valid bits
// Slot 0 (OS) can be saved into but never created or killed.
module process_scheduler_pid_table
    import process_scheduler_pkg::*;
#(
    parameter int unsigned NPROC = NPROC_DEFAULT,
    parameter int unsigned PCW   = PCW_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     save_en,
    input  logic [$clog2(NPROC)-1:0] save_pid,
    input  logic [PCW-1:0]           save_pc,
    input  logic                     create_en,
    input  logic [$clog2(NPROC)-1:0] create_pid,
    input  logic [PCW-1:0]           create_pc,
    input  logic                     kill_en,
    input  logic [$clog2(NPROC)-1:0] kill_pid,
    input  logic [$clog2(NPROC)-1:0] rd_pid,
    output logic [PCW-1:0]           rd_pc,
    output logic [NPROC-1:0]         valid
);
    localparam int unsigned PIDW = $clog2(NPROC);
    localparam logic [PIDW-1:0] OsPid = PIDW'(OS_PID);

    logic [PCW-1:0]   pc_q [NPROC];
    logic [NPROC-1:0] valid_q;
    logic             create_ok;
    logic             kill_ok;

    assign create_ok = create_en && (create_pid != OsPid);
    assign kill_ok   = kill_en && (kill_pid != OsPid);

    // Later non-blocking writes win: create over save, kill over create.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NPROC); i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            if (save_en) begin
                pc_q[save_pid] <= save_pc;
            end
            if (create_ok) begin
                pc_q[create_pid]    <= create_pc;
                valid_q[create_pid] <= 1'b1;
            end
            if (kill_ok) begin
                valid_q[kill_pid] <= 1'b0;
            end
        end
    end

    assign rd_pc = pc_q[rd_pid];
    assign valid = valid_q;

endmodule

// File: rtl/process_scheduler.sv
// Round-robin context-switch scheduler.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : cs_req/pc_in switch request, create/kill slot management,
//                  cur_pid/next_pc/switch_done/busy/idle_os results.
// A switch walks IDLE -> SAVE -> SEARCH (one candidate per cycle) -> LOAD.
// Optional: define PROCESS_SCHEDULER_STATS_EN to add switch_count and
// last_search_len on the bus.
module process_scheduler
    import process_scheduler_pkg::*;
#(
    parameter int unsigned NPROC = NPROC_DEFAULT,
    parameter int unsigned PCW   = PCW_DEFAULT
) (
    input logic                 clock,
    input logic                 reset,
    process_scheduler_if.slave  bus
);
    localparam int unsigned PIDW = $clog2(NPROC);
    localparam logic [PIDW-1:0] OsPid     = PIDW'(OS_PID);
    localparam logic [PIDW-1:0] FirstUser = PIDW'(1);
    localparam logic [PIDW-1:0] LastPid   = PIDW'(NPROC - 1);

    state_e          state_q, state_d;
    logic [PCW-1:0]  saved_pc_q, saved_pc_d;
    logic [PIDW-1:0] cand_q, cand_d;
    logic [PIDW-1:0] count_q, count_d;
    logic [PIDW-1:0] cur_pid_q, cur_pid_d;
    logic [PCW-1:0]  next_pc_q, next_pc_d;
    logic            idle_os_q, idle_os_d;

    logic [NPROC-1:0] valid;
    logic [PCW-1:0]   rd_pc;
    logic [PIDW-1:0]  rd_pid;
    logic             cand_valid;
    logic             save_en;

    // Round-robin successor over user slots; pid 0 is never a candidate.
    function automatic logic [PIDW-1:0] next_pid(input logic [PIDW-1:0] pid);
        return (pid == LastPid) ? FirstUser : pid + FirstUser;
    endfunction

    assign cand_valid = valid[cand_q];
    // Read the candidate when it is valid, else the OS slot for exhaustion.
    assign rd_pid     = cand_valid ? cand_q : OsPid;
    // A killed current process has nothing worth saving.
    assign save_en    = (state_q == StSave) && (valid[cur_pid_q] || (cur_pid_q == OsPid));

    process_scheduler_pid_table #(
        .NPROC (NPROC),
        .PCW   (PCW)
    ) u_pid_table (
        .clock      (clock),
        .reset      (reset),
        .save_en    (save_en),
        .save_pid   (cur_pid_q),
        .save_pc    (saved_pc_q),
        .create_en  (bus.create),
        .create_pid (bus.create_pid),
        .create_pc  (bus.create_pc),
        .kill_en    (bus.kill),
        .kill_pid   (bus.kill_pid),
        .rd_pid     (rd_pid),
        .rd_pc      (rd_pc),
        .valid      (valid)
    );

    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        cand_d     = cand_q;
        count_d    = count_q;
        cur_pid_d  = cur_pid_q;
        next_pc_d  = next_pc_q;
        idle_os_d  = idle_os_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cs_req) begin
                    saved_pc_d = bus.pc_in;
                    state_d    = StSave;
                end
            end
            StSave: begin
                cand_d  = next_pid(cur_pid_q);
                count_d = FirstUser;
                state_d = StSearch;
            end
            StSearch: begin
                // A valid candidate beats exhaustion on the last examined slot.
                if (cand_valid || (count_q == LastPid)) begin
                    cur_pid_d = rd_pid;
                    next_pc_d = rd_pc;
                    idle_os_d = !cand_valid;
                    state_d   = StLoad;
                end else begin
                    cand_d  = next_pid(cand_q);
                    count_d = count_q + FirstUser;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            saved_pc_q <= '0;
            cand_q     <= '0;
            count_q    <= '0;
            cur_pid_q  <= OsPid;
            next_pc_q  <= '0;
            idle_os_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            saved_pc_q <= saved_pc_d;
            cand_q     <= cand_d;
            count_q    <= count_d;
            cur_pid_q  <= cur_pid_d;
            next_pc_q  <= next_pc_d;
            idle_os_q  <= idle_os_d;
        end
    end

    assign bus.cur_pid     = cur_pid_q;
    assign bus.next_pc     = next_pc_q;
    assign bus.switch_done = (state_q == StLoad);
    assign bus.busy        = (state_q != StIdle);
    assign bus.idle_os     = idle_os_q;

`ifdef PROCESS_SCHEDULER_STATS_EN
    logic [15:0]     switch_count_q;
    logic [PIDW-1:0] last_len_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            switch_count_q <= '0;
            last_len_q     <= '0;
        end else begin
            if (state_q == StLoad) begin
                switch_count_q <= switch_count_q + 16'd1;
            end
            if ((state_q == StSearch) && (state_d == StLoad)) begin
                last_len_q <= count_q;
            end
        end
    end

    assign bus.switch_count    = switch_count_q;
    assign bus.last_search_len = last_len_q;
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: hand sequences for reset, kill during
// search, ignored cs_req, create/kill collisions and reset mid-switch, plus a
// table of chained switch vectors with hand-computed results.
module tb_process_scheduler;
    localparam int unsigned NPROC = 8;
    localparam int unsigned PCW   = 32;

    typedef struct {
        logic [7:0]  kill_mask;
        logic [7:0]  create_mask;
        logic [31:0] pc_in;
        int          k;
        logic [2:0]  pid;
        logic [31:0] pc;
        logic        idle;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    process_scheduler_if #(.NPROC(NPROC), .PCW(PCW)) bus ();

    process_scheduler #(
        .NPROC (NPROC),
        .PCW   (PCW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cs_req     = 1'b0;
        bus.pc_in      = '0;
        bus.create     = 1'b0;
        bus.create_pid = '0;
        bus.create_pc  = '0;
        bus.kill       = 1'b0;
        bus.kill_pid   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_create(input int pid, input logic [31:0] pc);
        bus.create     = 1'b1;
        bus.create_pid = 3'(pid);
        bus.create_pc  = pc;
        tick();
        bus.create     = 1'b0;
    endtask

    task automatic do_kill(input int pid);
        bus.kill     = 1'b1;
        bus.kill_pid = 3'(pid);
        tick();
        bus.kill     = 1'b0;
    endtask

    // Waits (bounded) for switch_done; lat counts cycles since cs_req.
    task automatic wait_done(inout int lat);
        while (bus.switch_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_switch(input logic [31:0] pc, output int lat);
        bus.cs_req = 1'b1;
        bus.pc_in  = pc;
        tick();
        bus.cs_req = 1'b0;
        lat = 1;
        wait_done(lat);
    endtask

    task automatic check_result(input string tag, input int lat, input int k,
                                input logic [2:0] pid, input logic [31:0] pc,
                                input logic idle);
        check({tag, " latency"}, 32'(lat), 32'(k + 2));
        check({tag, " cur_pid"}, 32'(bus.cur_pid), 32'(pid));
        check({tag, " next_pc"}, bus.next_pc, pc);
        check({tag, " idle_os"}, 32'(bus.idle_os), 32'(idle));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " cur_pid"}, 32'(bus.cur_pid), 32'd0);
        check({tag, " next_pc"}, bus.next_pc, 32'd0);
        check({tag, " switch_done"}, 32'(bus.switch_done), 32'd0);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " idle_os"}, 32'(bus.idle_os), 32'd1);
`ifdef PROCESS_SCHEDULER_STATS_EN
        check({tag, " switch_count"}, 32'(bus.switch_count), 32'd0);
`endif
    endtask

    initial begin
        vec_t vecs [11];
        int   lat;
        int   pulses;

        vecs[0]  = '{8'h00, 8'h00, 32'h040, 7, 3'd0, 32'h040, 1'b1};
        vecs[1]  = '{8'h00, 8'h26, 32'h044, 1, 3'd1, 32'h100, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 32'h1A0, 1, 3'd2, 32'h200, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 32'h2B0, 3, 3'd5, 32'h500, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 32'h5C0, 3, 3'd1, 32'h1A0, 1'b0};
        vecs[5]  = '{8'h06, 8'h00, 32'h1F0, 4, 3'd5, 32'h5C0, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 32'h2A0, 7, 3'd5, 32'h2A0, 1'b0};
        vecs[7]  = '{8'h20, 8'h80, 32'h333, 2, 3'd7, 32'h700, 1'b0};
        vecs[8]  = '{8'h80, 8'h00, 32'h777, 7, 3'd0, 32'h044, 1'b1};
        vecs[9]  = '{8'h00, 8'h41, 32'h088, 6, 3'd6, 32'h600, 1'b0};
        vecs[10] = '{8'h40, 8'h00, 32'h099, 7, 3'd0, 32'h088, 1'b1};

        clear_inputs();
        do_reset();
        check_reset_state("reset");

        // Create pid 3, switch from the kernel: candidates 1,2,3.
        do_create(3, 32'h100);
        do_switch(32'h040, lat);
        check_result("first", lat, 3, 3'd3, 32'h100, 1'b0);
        tick();
        check("first pulse width", 32'(bus.switch_done), 32'd0);

        // Kill pid 5 while candidate 4 is examined; a cs_req there is dropped.
        do_create(5, 32'h500);
        do_create(6, 32'h600);
        bus.cs_req = 1'b1;
        bus.pc_in  = 32'h3F0;
        tick();
        bus.cs_req = 1'b0;
        check("save busy", 32'(bus.busy), 32'd1);
        tick();
        bus.kill     = 1'b1;
        bus.kill_pid = 3'd5;
        bus.cs_req   = 1'b1;
        bus.pc_in    = 32'hDEAD;
        tick();
        clear_inputs();
        lat = 3;
        wait_done(lat);
        check_result("kill in search", lat, 3, 3'd6, 32'h600, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.switch_done === 1'b1) pulses++;
        end
        check("dropped cs_req pulses", 32'(pulses), 32'd0);
        check("dropped cs_req busy", 32'(bus.busy), 32'd0);

        // Create+kill pid 2 together (kill wins); create on cur_pid in SAVE wins.
        bus.create     = 1'b1;
        bus.create_pid = 3'd2;
        bus.create_pc  = 32'h222;
        bus.kill       = 1'b1;
        bus.kill_pid   = 3'd2;
        tick();
        clear_inputs();
        bus.cs_req = 1'b1;
        bus.pc_in  = 32'h6F0;
        tick();
        bus.cs_req     = 1'b0;
        bus.create     = 1'b1;
        bus.create_pid = 3'd6;
        bus.create_pc  = 32'h6AA;
        tick();
        clear_inputs();
        lat = 2;
        wait_done(lat);
        check_result("collide", lat, 4, 3'd3, 32'h3F0, 1'b0);
        tick();
        do_kill(3);
        do_switch(32'h3FF, lat);
        check_result("create wins save", lat, 3, 3'd6, 32'h6AA, 1'b0);
        tick();

        // Chained vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            for (int p = 0; p < 8; p++) begin
                if (vecs[i].kill_mask[p]) do_kill(p);
            end
            for (int p = 0; p < 8; p++) begin
                if (vecs[i].create_mask[p]) do_create(p, 32'(p) * 32'h100);
            end
            do_switch(vecs[i].pc_in, lat);
            check_result($sformatf("vec%0d", i), lat, vecs[i].k, vecs[i].pid,
                         vecs[i].pc, vecs[i].idle);
            tick();
            check($sformatf("vec%0d done low", i), 32'(bus.switch_done), 32'd0);
            check($sformatf("vec%0d busy low", i), 32'(bus.busy), 32'd0);
`ifdef PROCESS_SCHEDULER_STATS_EN
            check($sformatf("vec%0d switch_count", i), 32'(bus.switch_count), 32'(i + 1));
            check($sformatf("vec%0d last_search_len", i), 32'(bus.last_search_len),
                  32'(vecs[i].k));
`endif
        end

        // Reset in SEARCH aborts the switch and beats cs_req/create.
        do_create(6, 32'h600);
        bus.cs_req = 1'b1;
        bus.pc_in  = 32'h123;
        tick();
        bus.cs_req = 1'b0;
        tick();
        reset          = 1'b1;
        bus.cs_req     = 1'b1;
        bus.create     = 1'b1;
        bus.create_pid = 3'd4;
        bus.create_pc  = 32'h444;
        tick();
        reset = 1'b0;
        clear_inputs();
        check_reset_state("mid reset");
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.switch_done === 1'b1) pulses++;
            tick();
        end
        check("mid reset pulses", 32'(pulses), 32'd0);
        do_switch(32'h055, lat);
        check_result("after reset", lat, 7, 3'd0, 32'h055, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
